// File: rtl/video_frame_arbiter.sv
// Frame-boundary arbiter for genlocked video sources: source 0 is timing master and default owner.
// Ownership changes only on a vsync rise, optionally with black frames inserted between owners.
module video_frame_arbiter #(
    parameter int unsigned NUM_SOURCES = 2,
    parameter int unsigned MUTE_FRAMES = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [24*NUM_SOURCES-1:0]   src_data,
    input  logic [NUM_SOURCES-1:0]      src_de,
    input  logic [NUM_SOURCES-1:0]      src_hsync,
    input  logic [NUM_SOURCES-1:0]      src_vsync,
    input  logic [NUM_SOURCES-1:0]      request,
    output logic [23:0]                 video_data,
    output logic                        video_de,
    output logic                        video_hsync,
    output logic                        video_vsync,
    output logic [NUM_SOURCES-1:0]      grant,
    output logic                        muted,
    output logic                        switch_done
);

    localparam int unsigned PIX_W = 24;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        PENDING = 2'd1,
        MUTE    = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [NUM_SOURCES-1:0]   grant_n;
    logic [NUM_SOURCES-1:0]   nxt;
    logic [NUM_SOURCES-1:0]   nxt_n;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_n;
    logic                     done_n;
    logic                     vsync_d;
    logic                     frame_start_c;
    logic [NUM_SOURCES-1:0]   target_c;
    logic [PIX_W-1:0]         sel_data_c;

    // Only source 0 carries timing and request[0] is implied; the rest are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{src_de[NUM_SOURCES-1:1], src_hsync[NUM_SOURCES-1:1],
                         src_vsync[NUM_SOURCES-1:1], request[0]};

    assign frame_start_c = src_vsync[0] & ~vsync_d;

    // Highest requesting index wins; source 0 when nobody asks.
    always_comb begin
        target_c = NUM_SOURCES'(1);
        for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
            if (request[i]) begin
                target_c = NUM_SOURCES'(1) << i;
            end
        end
    end

    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
            if (grant[i]) begin
                sel_data_c = src_data[PIX_W*i +: PIX_W];
            end
        end
    end

    // Next-state logic: ownership only moves on a frame start.
    always_comb begin
        state_n = state;
        grant_n = grant;
        nxt_n   = nxt;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            ACTIVE: begin
                if (target_c != grant) begin
                    state_n = PENDING;
                end
            end
            PENDING: begin
                if (target_c == grant) begin
                    state_n = ACTIVE;
                end else if (frame_start_c) begin
                    if (MUTE_FRAMES > 0) begin
                        nxt_n   = target_c;
                        cnt_n   = CNT_W'(MUTE_FRAMES);
                        state_n = MUTE;
                    end else begin
                        grant_n = target_c;
                        done_n  = 1'b1;
                        state_n = ACTIVE;
                    end
                end
            end
            MUTE: begin
                if (frame_start_c) begin
                    if (cnt > CNT_W'(1)) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        grant_n = nxt;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        state_n = ACTIVE;
                    end
                end
            end
            default: begin
                state_n = ACTIVE;
            end
        endcase
    end

    // Output stage reflects the state before this cycle's update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ACTIVE;
            grant       <= NUM_SOURCES'(1);
            nxt         <= NUM_SOURCES'(1);
            cnt         <= '0;
            vsync_d     <= 1'b0;
            video_data  <= '0;
            video_de    <= 1'b0;
            video_hsync <= 1'b0;
            video_vsync <= 1'b0;
            muted       <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            nxt         <= nxt_n;
            cnt         <= cnt_n;
            vsync_d     <= src_vsync[0];
            video_data  <= ((state == MUTE) || !src_de[0]) ? '0 : sel_data_c;
            video_de    <= src_de[0];
            video_hsync <= src_hsync[0];
            video_vsync <= src_vsync[0];
            muted       <= (state == MUTE);
            switch_done <= done_n;
        end
    end

endmodule
